// File: rtl/io_bus_responder.sv
// Port-I/O responder: LED register, synchronized switches, debounced button with
// sticky press latch, prescaled timer. Define IO_IRQ_EN to add IRQ_MASK and irq.
module io_bus_responder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PRESCALE        = 1000
) (
   input  logic        clk,
   input  logic        sync_rst,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   input  logic        write,
   output logic [15:0] data_out,
   output logic [7:0]  LED,
   input  logic        button_1,
   input  logic [3:0]  switches,
   output logic        irq
);

   localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE - 1);

   localparam logic [15:0] ADDR_LED    = 16'h0000;
   localparam logic [15:0] ADDR_SWITCH = 16'h0001;
   localparam logic [15:0] ADDR_BUTTON = 16'h0002;
   localparam logic [15:0] ADDR_TIMER  = 16'h0003;
   localparam logic [15:0] ADDR_MASK   = 16'h0004;

   logic           btn_meta_q, btn_sync_q;
   logic [3:0]     sw_meta_q, sw_sync_q;
   logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
   logic           deb_lvl_q, deb_lvl_d;
   logic           press_q, press_d;
   logic           press_rise;
   logic [PSW-1:0] pre_q, pre_d;
   logic [15:0]    timer_q, timer_d;
   logic [7:0]     led_q, led_d;
   logic [15:0]    dout_q, dout_d;

   logic wr_led, wr_btn, wr_tmr;

   assign wr_led = write && (addr == ADDR_LED);
   assign wr_btn = write && (addr == ADDR_BUTTON);
   assign wr_tmr = write && (addr == ADDR_TIMER);

   // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      deb_cnt_d  = deb_cnt_q;
      deb_lvl_d  = deb_lvl_q;
      press_rise = 1'b0;
      if (btn_sync_q == deb_lvl_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_lvl_d  = ~deb_lvl_q;
         deb_cnt_d  = '0;
         press_rise = ~deb_lvl_q;
      end else begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end
   end

   // Set is evaluated last so a coincident press beats the clear write.
   always_comb begin
      press_d = press_q;
      if (wr_btn && data[1]) press_d = 1'b0;
      if (press_rise)        press_d = 1'b1;
   end

   always_comb begin
      pre_d   = pre_q;
      timer_d = timer_q;
      if (wr_tmr) begin
         timer_d = data;
         pre_d   = '0;
      end else if (pre_q == PRE_LAST) begin
         timer_d = timer_q + 16'd1;
         pre_d   = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_comb begin
      led_d = led_q;
      if (wr_led) led_d = data[7:0];
   end

`ifdef IO_IRQ_EN
   logic mask_q, mask_d;
   logic irq_q, irq_d;

   always_comb begin
      mask_d = mask_q;
      if (write && (addr == ADDR_MASK)) mask_d = data[0];
      irq_d = press_q & mask_q;
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         mask_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Read mux sees pre-write state, so same-cycle writes show up a cycle later.
   always_comb begin
      dout_d = '0;
      case (addr)
         ADDR_LED:    dout_d = {8'h00, led_q};
         ADDR_SWITCH: dout_d = {12'h000, sw_sync_q};
         ADDR_BUTTON: dout_d = {14'h0000, press_q, deb_lvl_q};
         ADDR_TIMER:  dout_d = timer_q;
`ifdef IO_IRQ_EN
         ADDR_MASK:   dout_d = {15'h0000, mask_q};
`endif
         default:     dout_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         deb_cnt_q  <= '0;
         deb_lvl_q  <= 1'b0;
         press_q    <= 1'b0;
         pre_q      <= '0;
         timer_q    <= '0;
         led_q      <= '0;
         dout_q     <= '0;
      end else begin
         btn_meta_q <= button_1;
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= switches;
         sw_sync_q  <= sw_meta_q;
         deb_cnt_q  <= deb_cnt_d;
         deb_lvl_q  <= deb_lvl_d;
         press_q    <= press_d;
         pre_q      <= pre_d;
         timer_q    <= timer_d;
         led_q      <= led_d;
         dout_q     <= dout_d;
      end
   end

   assign data_out = dout_q;
   assign LED      = led_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder (DEBOUNCE_CYCLES=4, PRESCALE=3);
// irq expectations follow whether IO_IRQ_EN is defined for the build.
module tb_io_bus_responder;

   logic        clk = 1'b0;
   logic        sync_rst = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] data = '0;
   logic        write = 1'b0;
   logic [15:0] data_out;
   logic [7:0]  LED;
   logic        button_1 = 1'b0;
   logic [3:0]  switches = '0;
   logic        irq;

`ifdef IO_IRQ_EN
   localparam logic [15:0] IRQ_ON  = 16'h0001;
   localparam logic [15:0] MASK_RD = 16'h0001;
`else
   localparam logic [15:0] IRQ_ON  = 16'h0000;
   localparam logic [15:0] MASK_RD = 16'h0000;
`endif

   io_bus_responder #(.DEBOUNCE_CYCLES(4), .PRESCALE(3)) dut (
      .clk      (clk),
      .sync_rst (sync_rst),
      .addr     (addr),
      .data     (data),
      .write    (write),
      .data_out (data_out),
      .LED      (LED),
      .button_1 (button_1),
      .switches (switches),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        wr;
      logic [15:0] exp_dout;
      logic [7:0]  exp_led;
   } vec_t;

   typedef struct {
      string       nm;
      logic [15:0] v;
   } exp_t;

   vec_t vecs[16];
   exp_t sbq[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_pop_check();
      exp_t e;
      if (sbq.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sbq.pop_front();
         chk(e.nm, data_out, e.v);
      end
   endtask

   initial begin
      vecs[0]  = '{16'h0000, 16'h12A5, 1'b1, 16'h0000, 8'hA5};
      vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 16'h00A5, 8'hA5};
      vecs[2]  = '{16'h0001, 16'hFFFF, 1'b1, 16'h000A, 8'hA5};
      vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h00A5, 8'hA5};
      vecs[4]  = '{16'h0005, 16'h1234, 1'b1, 16'h0000, 8'hA5};
      vecs[5]  = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000, 8'hA5};
      vecs[6]  = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 8'hA5};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h00A5, 8'hA5};
      vecs[8]  = '{16'h0002, 16'h0000, 1'b0, 16'h0000, 8'hA5};
      vecs[9]  = '{16'h0004, 16'h0001, 1'b1, 16'h0000, 8'hA5};
      vecs[10] = '{16'h0004, 16'h0000, 1'b0, MASK_RD,  8'hA5};
      vecs[11] = '{16'h0004, 16'h0000, 1'b1, MASK_RD,  8'hA5};
      vecs[12] = '{16'h0004, 16'h0000, 1'b0, 16'h0000, 8'hA5};
      vecs[13] = '{16'h0000, 16'h00C3, 1'b1, 16'h00A5, 8'hC3};
      vecs[14] = '{16'h0000, 16'h00C3, 1'b1, 16'h00C3, 8'hC3};
      vecs[15] = '{16'h0000, 16'h0000, 1'b0, 16'h00C3, 8'hC3};

      // reset state
      repeat (2) tick();
      chk("reset_led", {8'h00, LED}, 16'h0000);
      chk("reset_dout", data_out, 16'h0000);
      chk("reset_irq", {15'h0000, irq}, 16'h0000);
      sync_rst = 1'b0;
      switches = 4'b1010;
      repeat (3) tick();

      // register map vectors
      for (int i = 0; i < 16; i++) begin
         addr  = vecs[i].addr;
         data  = vecs[i].data;
         write = vecs[i].wr;
         sbq.push_back('{$sformatf("vec%0d_dout", i), vecs[i].exp_dout});
         tick();
         sb_pop_check();
         chk($sformatf("vec%0d_led", i), {8'h00, LED}, {8'h00, vecs[i].exp_led});
      end
      write = 1'b0;

      // held write level
      addr = 16'h0000; data = 16'h12A5; write = 1'b1;
      tick();
      chk("held_first_dout", data_out, 16'h00C3);
      repeat (9) tick();
      chk("held_led", {8'h00, LED}, 16'h00A5);
      chk("held_dout", data_out, 16'h00A5);
      write = 1'b0;

      // switch synchronizer latency
      addr = 16'h0001;
      tick();
      chk("sw_base", data_out, 16'h000A);
      switches = 4'b0101;
      tick();
      chk("sw_lat1", data_out, 16'h000A);
      tick();
      chk("sw_lat2", data_out, 16'h000A);
      tick();
      chk("sw_lat3", data_out, 16'h0005);

      // 3-cycle glitch must not pass the debouncer
      addr = 16'h0002;
      button_1 = 1'b1;
      repeat (3) tick();
      button_1 = 1'b0;
      repeat (6) tick();
      chk("glitch_btn", data_out, 16'h0000);

      // real press: level flips after 2+4 edges
      button_1 = 1'b1;
      repeat (6) tick();
      chk("press_edge6", data_out, 16'h0000);
      tick();
      chk("press_edge7", data_out, 16'h0003);

      // data[1]=0 write leaves the latch alone
      data = 16'h0001; write = 1'b1;
      tick();
      chk("noclr_wr", data_out, 16'h0003);
      write = 1'b0;
      tick();
      chk("noclr_rd", data_out, 16'h0003);

      // clear the latch
      data = 16'h0002; write = 1'b1;
      tick();
      chk("clr_prewrite", data_out, 16'h0003);
      write = 1'b0;
      tick();
      chk("clr_rd", data_out, 16'h0001);

      // enable mask, release the button
      addr = 16'h0004; data = 16'h0001; write = 1'b1;
      tick();
      write = 1'b0; addr = 16'h0002;
      button_1 = 1'b0;
      repeat (8) tick();
      chk("release_btn", data_out, 16'h0000);

      // press edge coincident with clear write: set wins
      button_1 = 1'b1;
      repeat (5) tick();
      data = 16'h0002; write = 1'b1;
      tick();
      write = 1'b0;
      chk("irq_at_set", {15'h0000, irq}, 16'h0000);
      tick();
      chk("coincide_btn", data_out, 16'h0003);
      chk("irq_after_set", {15'h0000, irq}, IRQ_ON);
      data = 16'h0002; write = 1'b1;
      tick();
      write = 1'b0;
      chk("irq_at_clr", {15'h0000, irq}, IRQ_ON);
      tick();
      chk("irq_after_clr", {15'h0000, irq}, 16'h0000);
      chk("clr2_rd", data_out, 16'h0001);

      // timer wrap with PRESCALE=3
      addr = 16'h0003; data = 16'hFFFE; write = 1'b1;
      tick();
      write = 1'b0;
      repeat (3) tick();
      chk("tmr_e3", data_out, 16'hFFFE);
      tick();
      chk("tmr_e4", data_out, 16'hFFFF);
      repeat (2) tick();
      chk("tmr_e6", data_out, 16'hFFFF);
      tick();
      chk("tmr_e7", data_out, 16'h0000);
      tick();
      data = 16'h1234; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      chk("tmr_wr_at_wrap", data_out, 16'h1234);
      repeat (2) tick();
      chk("tmr_wr_e12", data_out, 16'h1234);
      tick();
      chk("tmr_wr_e13", data_out, 16'h1235);

      // asynchronous reset mid-debounce with timer running
      addr = 16'h0000; data = 16'h005A; write = 1'b1;
      tick();
      write = 1'b0; addr = 16'h0003;
      button_1 = 1'b0;
      repeat (3) tick();
      chk("pre_rst_led", {8'h00, LED}, 16'h005A);
      #2 sync_rst = 1'b1;
      #1;
      chk("arst_led", {8'h00, LED}, 16'h0000);
      chk("arst_dout", data_out, 16'h0000);
      chk("arst_irq", {15'h0000, irq}, 16'h0000);
      tick();
      sync_rst = 1'b0;
      tick();
      chk("arst_timer", data_out, 16'h0000);
      addr = 16'h0002;
      tick();
      chk("arst_btn", data_out, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Responder end of the CPU port-I/O interface driven by `pst`/`pld`.
- Decodes a 16-bit port address and holds the LED output register.
- Synchronizes and debounces the switch and push-button inputs, and provides a prescaled free-running timer.
- Returns read data one cycle after the address is presented.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before the debounced button level changes (>=1).
- PRESCALE, 1000, clk cycles per timer increment (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- sync_rst  input  1  asynchronous, active-high reset.
- addr  input  16  port address; held by the initiator between accesses.
- data  input  16  write data; valid while write=1.
- write  input  1  write enable, level; may stay high for many cycles.
- data_out  output  16  registered read data for addr.
- LED  output  8  LED register.
- button_1  input  1  raw push-button, asynchronous.
- switches  input  4  raw switches, asynchronous.
- irq  output  1  interrupt request (see Optional Feature).

Behaviour:
- Reset (async, active-high): all outputs and state go to 0.
  - LED=0, data_out=0, irq=0.
  - Synchronizers, debounce counter, debounced level, press latch, prescaler and timer all 0.
  - Reset may assert mid-access; nothing partial survives it.
- Synchronizers: button_1 and switches[3:0] each pass through a 2-flop synchronizer. Logic uses only the synchronized values.
- Debounce:
  - When the synchronized button equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Worst-case press latency is 2 + DEBOUNCE_CYCLES cycles.
- Press latch: sets on a 0->1 edge of the debounced level. Sticky until cleared by a write.
- Register map. Writes take effect on every clk edge with write=1; all writes are idempotent, so a held write level is harmless.
  - 0x0000 LED: R/W. Write LED<=data[7:0]. Read {8'h00, LED}.
  - 0x0001 SWITCH: RO. Read {12'h000, synced switches}.
  - 0x0002 BUTTON: read {14'h0, press_latch, debounced_level}. Write data[1]=1 clears press_latch. Write data[1]=0 has no effect.
  - 0x0003 TIMER: R/W 16-bit. Write loads data and clears the prescaler.
  - 0x0004 IRQ_MASK: see Optional Feature.
  - Any other address reads 0x0000; writes are ignored.
- Timer:
  - The prescaler counts 0..PRESCALE-1.
  - On the wrap the timer increments; 0xFFFF wraps to 0x0000 with no flag.
  - A same-cycle timer write beats the tick.
- Read path: data_out<=mux(addr) every cycle, regardless of write. Latency is 1 cycle from addr change.
  - A read in the same cycle as a write to the same register returns the pre-write value.
  - The new value appears the following cycle.
- Simultaneous events:
  - A press-latch set edge and a clear write in the same cycle: set wins, latch=1.
  - Writes to unmapped addresses never disturb state.

Optional Feature:
- Macro IO_IRQ_EN.
- Defined:
  - 0x0004 IRQ_MASK is R/W, bit0 only: write mask<=data[0], read {15'h0, mask}; reset 0.
  - irq is registered: irq<=press_latch & mask, so it asserts one cycle after the latch sets with mask=1.
  - irq clears one cycle after the latch is cleared or the mask is cleared.
- Not defined: irq is tied 0, and 0x0004 behaves as unmapped (reads 0, writes ignored).

Test Plan:
- Reset, then addr=0x0000, write=1, data=0x12A5 for 1 cycle -> LED=0xA5; addr=0 with write=0 gives data_out=0x00A5 next cycle. Held write for 10 cycles gives the same result.
- switches=4'b1010, addr=0x0001 -> data_out=0x000A within 3 cycles; switches change at cycle 0 becomes visible at cycle 3.
- DEBOUNCE_CYCLES=4: button glitches high for 3 cycles -> BUTTON reads 0x0000. Held high for 10 cycles -> BUTTON reads 0x0003. Write 0x0002 to 0x0002 -> reads 0x0001. Press edge coincident with the clear write -> latch stays 1.
- PRESCALE=3: write 0xFFFE to 0x0003 -> timer 0xFFFF after 3 cycles, 0x0000 after 6 cycles. Write at a prescaler wrap -> written value kept, no increment.
- Assert sync_rst asynchronously mid-debounce with LED=0x5A and timer running -> LED, data_out, timer, latch and irq go to 0 immediately, without a clock edge.
- IO_IRQ_EN defined: mask=1, then press -> irq=1 one cycle after the latch sets; clear the latch -> irq=0 next cycle. Build without the macro -> irq stays 0 and 0x0004 reads 0.
